// File: rtl/stutter_trace_observer.sv
// Environment-side observer for a stuttering codeblock.
// It drives the codeblock's stutter input from a scheduler request and
// forces a step after MAX_STUTTER consecutive requested stutters. It logs
// every change of the codeblock's public output, stamped with the step
// index, into a FIFO. When the FIFO is almost full it holds the codeblock
// with stutter, so that no observation is lost.
module stutter_trace_observer #(
  parameter int DATA_W      = 2,
  parameter int TIME_W      = 8,
  parameter int DEPTH       = 8,
  parameter int MAX_STUTTER = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sched_req,
  output logic                           stutter_out,
  input  logic [DATA_W-1:0]              public_in,
  output logic                           obs_valid,
  input  logic                           obs_ready,
  output logic [TIME_W+DATA_W-1:0]       obs_data,
  output logic [$clog2(DEPTH):0]         obs_count,
  output logic                           obs_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RUN_W = $clog2(MAX_STUTTER + 1);
  localparam int ENT_W = TIME_W + DATA_W;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [TIME_W-1:0] step_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [DATA_W-1:0] prev_pub;
  logic              overflow;

  logic almost_full;
  logic full;
  logic sched_stutter;
  logic stutter_req;
  logic change;
  logic pop;
  logic push_ok;

  // Stutter decision and FIFO handshake; backpressure overrides fairness.
  always_comb begin
    almost_full   = (count >= CNT_W'(DEPTH - 1));
    full          = (count == CNT_W'(DEPTH));
    sched_stutter = sched_req & (run_cnt < RUN_W'(MAX_STUTTER));
    stutter_req   = almost_full | sched_stutter;
    change        = (public_in != prev_pub);
    pop           = (count != '0) & obs_ready;
    // When full, a push fits only if the head leaves in the same cycle.
    push_ok       = change & (~full | pop);
  end

  assign stutter_out  = rst | stutter_req;
  assign obs_valid    = (count != '0);
  assign obs_data     = mem[rd_ptr];
  assign obs_count    = count;
  assign obs_overflow = overflow;

  // Step stamp and fairness run length; a backpressure stall freezes the run length.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= '0;
      run_cnt  <= '0;
    end else if (!stutter_req) begin
      step_cnt <= step_cnt + TIME_W'(1);
      run_cnt  <= '0;
    end else if (!almost_full) begin
      run_cnt  <= run_cnt + RUN_W'(1);
    end
  end

  // FIFO pointers, occupancy, sticky overflow and change tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      prev_pub <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (change && full && !pop) overflow <= 1'b1;
      // A dropped entry still updates prev_pub, so it is not reported twice.
      if (change) prev_pub <= public_in;
    end
  end

  // Entry storage: the stamp is the step count before this edge's increment.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= {step_cnt, public_in};
  end

endmodule
